// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared types for the network stream driver
package nn_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drv_state_t;

    localparam int T = 16;

    typedef logic signed [T-1:0] word_t;

endpackage

// File: rtl/nn_lfsr16.sv
// rtl/nn_lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) used for stream throttling
module nn_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else if (enable) begin
            state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/nn_stream_driver.sv
// rtl/nn_stream_driver.sv - replays a stored input stream into a network and checks its output stream
module nn_stream_driver
    import nn_stream_pkg::*;
#(
    parameter int          T         = nn_stream_pkg::T,
    parameter int          NUM_IN    = 10000,
    parameter int          NUM_OUT   = 40000,
    parameter bit          THROTTLE  = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         load_en,
    input  logic         load_sel,
    input  logic [31:0]  load_addr,
    input  logic [T-1:0] load_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [T-1:0] m_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [T-1:0] s_data,
    output logic         busy,
    output logic         done,
    output logic [31:0]  err_count,
    output logic [31:0]  first_err
);

    localparam logic [31:0] NIN  = 32'(NUM_IN);
    localparam logic [31:0] NOUT = 32'(NUM_OUT);
    localparam int IAW = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
    localparam int OAW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    drv_state_t state, state_next;

    logic         run;
    logic         start_run;
    logic [15:0]  lfsr_state;
    logic         tx_en, rx_en;

    logic [T-1:0] in_mem  [NUM_IN];
    logic [T-1:0] exp_mem [NUM_OUT];

    logic [31:0]  j, tx_addr;
    logic [T-1:0] tx_q, tx_hold;
    logic         tx_qv, tx_hv, tx_fire, tx_take, tx_rd;

    logic [31:0]  i, rx_addr;
    logic [T-1:0] rx_q, rx_hold;
    logic         rx_qv, rx_hv, rx_fire, rx_take, rx_rd, rx_last;

    assign run       = (state == RUN);
    assign start_run = start && (state != RUN);
    assign busy      = run;
    assign done      = (state == DONE);

    nn_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .enable(run),
        .state (lfsr_state)
    );

    assign tx_en = !THROTTLE || lfsr_state[0];
    assign rx_en = !THROTTLE || lfsr_state[1];

    assign m_valid = run && tx_hv && (j < NIN) && tx_en;
    assign m_data  = m_valid ? tx_hold : '0;
    assign s_ready = run && rx_hv && (i < NOUT) && rx_en;

    assign tx_fire = m_valid && m_ready;
    assign rx_fire = s_valid && s_ready;
    assign rx_last = rx_fire && (i == NOUT - 32'd1);

    // RAM output register acts as the second stage behind the holding register, so a
    // read is only issued when the word already sitting there is being consumed.
    assign tx_take = tx_qv && (!tx_hv || tx_fire);
    assign tx_rd   = run && (tx_addr < NIN) && (!tx_qv || tx_take);
    assign rx_take = rx_qv && (!rx_hv || rx_fire);
    assign rx_rd   = run && (rx_addr < NOUT) && (!rx_qv || rx_take);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)   state_next = RUN;
            RUN:     if (rx_last) state_next = DONE;
            DONE:    if (start)   state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_en && !run && !load_sel && (load_addr < NIN)) begin
            in_mem[load_addr[IAW-1:0]] <= load_data;
        end
        if (tx_rd) begin
            tx_q <= in_mem[tx_addr[IAW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && !run && load_sel && (load_addr < NOUT)) begin
            exp_mem[load_addr[OAW-1:0]] <= load_data;
        end
        if (rx_rd) begin
            rx_q <= exp_mem[rx_addr[OAW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_run) begin
            j       <= '0;
            tx_addr <= '0;
            tx_qv   <= 1'b0;
            tx_hv   <= 1'b0;
            tx_hold <= '0;
        end else if (run) begin
            if (tx_fire) begin
                j <= j + 32'd1;
            end
            if (tx_rd) begin
                tx_addr <= tx_addr + 32'd1;
                tx_qv   <= 1'b1;
            end else if (tx_take) begin
                tx_qv <= 1'b0;
            end
            if (tx_take) begin
                tx_hold <= tx_q;
                tx_hv   <= 1'b1;
            end else if (tx_fire) begin
                tx_hv <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_run) begin
            i         <= '0;
            rx_addr   <= '0;
            rx_qv     <= 1'b0;
            rx_hv     <= 1'b0;
            rx_hold   <= '0;
            err_count <= '0;
            first_err <= '1;
        end else if (run) begin
            if (rx_rd) begin
                rx_addr <= rx_addr + 32'd1;
                rx_qv   <= 1'b1;
            end else if (rx_take) begin
                rx_qv <= 1'b0;
            end
            if (rx_take) begin
                rx_hold <= rx_q;
                rx_hv   <= 1'b1;
            end else if (rx_fire) begin
                rx_hv <= 1'b0;
            end
            if (rx_fire) begin
                i <= i + 32'd1;
                if (s_data != rx_hold) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 32'd1;
                    end
                    if (first_err == '1) begin
                        first_err <= i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nn_stream_driver.sv
// tb/tb_nn_stream_driver.sv - loopback bench for nn_stream_driver with scoreboard checking
module tb_nn_stream_driver;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset, start, load_en, load_sel;
    logic [31:0] load_addr;
    logic [15:0] load_data;
    logic        m_valid, m_ready, s_valid, s_ready, busy, done;
    logic [15:0] m_data, s_data;
    logic [31:0] err_count, first_err;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] in_m  [N];
    logic [15:0] exp_m [N];
    logic [15:0] txq [$];
    int          tx_acc, rx_acc;
    bit          mon_en = 1'b0;
    bit          stall_mode = 1'b0;
    logic        acc_en;
    logic        sl_full;
    logic [15:0] sl_data;

    always #5 clk = ~clk;

    nn_stream_driver #(
        .T(16), .NUM_IN(N), .NUM_OUT(N), .THROTTLE(1'b1), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .busy(busy), .done(done), .err_count(err_count), .first_err(first_err)
    );

    // one-deep register slice closing the loop from the tx port back to the rx port
    assign m_ready = !sl_full && acc_en;
    assign s_valid = sl_full;
    assign s_data  = sl_data;

    always @(posedge clk) begin
        if (reset) begin
            sl_full <= 1'b0;
        end else begin
            if (sl_full && s_ready) sl_full <= 1'b0;
            if (m_valid && m_ready) begin
                sl_full <= 1'b1;
                sl_data <= m_data;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            acc_en = stall_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (m_valid) begin
                if (txq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_extra actual=%0h required=none", m_data);
                end else begin
                    chk("tx_word", m_data, txq[0]);
                    if (m_ready) begin
                        void'(txq.pop_front());
                        tx_acc++;
                    end
                end
            end else begin
                chk("m_data_idle", m_data, 32'd0);
            end
            if (s_valid && s_ready) rx_acc++;
        end
    end

    task automatic write_word(input logic sel, input logic [31:0] addr, input logic [15:0] data);
        @(posedge clk);
        #1;
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = addr;
        load_data = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < N; k++) begin
            write_word(1'b0, k, in_m[k]);
            write_word(1'b1, k, exp_m[k]);
        end
        write_word(1'b0, N, 16'hDEAD);
        write_word(1'b1, N, 16'hBEEF);
        write_word(1'b0, 32'h8000_0000, 16'h1234);
        write_word(1'b1, 32'h8000_0001, 16'h5678);
    endtask

    task automatic start_pulse();
        txq.delete();
        for (int k = 0; k < N; k++) txq.push_back(in_m[k]);
        tx_acc = 0;
        rx_acc = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int          n;
        int          errs;
        logic [31:0] first;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        errs  = 0;
        first = '1;
        for (int k = 0; k < N; k++) begin
            if (in_m[k] != exp_m[k]) begin
                errs++;
                if (first == '1) first = k;
            end
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_count"}, err_count, errs);
        chk({tag, "_first_err"}, first_err, first);
        chk({tag, "_tx_sent"}, tx_acc, N);
        chk({tag, "_rx_recv"}, rx_acc, N);
        chk({tag, "_txq_left"}, txq.size(), 0);
    endtask

    task automatic new_vectors();
        for (int k = 0; k < N; k++) begin
            in_m[k]  = 16'($urandom);
            exp_m[k] = in_m[k];
        end
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        load_sel  = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", first_err, 32'hFFFF_FFFF);
        reset = 1'b0;

        new_vectors();
        load_all();
        mon_en = 1'b1;

        stall_mode = 1'b0;
        start_pulse();
        finish_run("loopback");

        exp_m[5] = exp_m[5] ^ 16'h0040;
        load_all();
        stall_mode = 1'b1;
        start_pulse();
        finish_run("inject5");

        exp_m[5] = in_m[5];
        exp_m[2] = ~in_m[2];
        exp_m[6] = in_m[6] + 16'd1;
        load_all();
        start_pulse();
        finish_run("inject26");

        new_vectors();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 2) == 0) exp_m[k] = in_m[k] ^ 16'(1 << $urandom_range(0, 15));
        end
        load_all();
        start_pulse();
        finish_run("random");

        for (int k = 0; k < N; k++) exp_m[k] = in_m[k];
        load_all();
        stall_mode = 1'b0;
        start_pulse();
        n = 0;
        while (tx_acc < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_j4", tx_acc, 4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err_count", err_count, 0);
        reset = 1'b0;
        stall_mode = 1'b1;
        start_pulse();
        finish_run("restart");

        start_pulse();
        for (int k = N - 1; k >= 4; k--) begin
            write_word(1'b0, k, ~in_m[k]);
            write_word(1'b1, k, ~exp_m[k]);
        end
        finish_run("load_guard");
        stall_mode = 1'b0;
        start_pulse();
        finish_run("retained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
